// File: rtl/ibus_pkg.sv
// Shared sizes, FSM states and lane helpers for the IBUS initiator.
package ibus_pkg;

  localparam int unsigned AW = 28;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_WORD = 2'd1,
    SZ_LONG = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } state_e;

  // Big-endian lanes: bit 3 is byte offset 0; the reserved size falls into long.
  function automatic logic [BW-1:0] lane_en(input logic [1:0] sz, input logic [1:0] a);
    logic [BW-1:0] ba;
    case (sz)
      SZ_BYTE: ba = 4'b1000 >> a;
      SZ_WORD: ba = a[1] ? 4'b0011 : 4'b1100;
      default: ba = 4'b1111;
    endcase
    return ba;
  endfunction

  function automatic logic [DW-1:0] wr_rep(input logic [1:0] sz, input logic [DW-1:0] d);
    logic [DW-1:0] r;
    case (sz)
      SZ_BYTE: r = {4{d[7:0]}};
      SZ_WORD: r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [DW-1:0] rd_ext(input logic [BW-1:0] ba, input logic [DW-1:0] di);
    logic [DW-1:0] r;
    case (ba)
      4'b1000: r = {24'h000000, di[31:24]};
      4'b0100: r = {24'h000000, di[23:16]};
      4'b0010: r = {24'h000000, di[15:8]};
      4'b0001: r = {24'h000000, di[7:0]};
      4'b1100: r = {16'h0000, di[31:16]};
      4'b0011: r = {16'h0000, di[15:0]};
      default: r = di;
    endcase
    return r;
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
    logic m;
    case (sz)
      SZ_BYTE: m = 1'b0;
      SZ_WORD: m = a[0];
      default: m = |a;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ibus_master_if.sv
// Core-side request port and IBUS initiator signals bundled for the master.
interface ibus_master_if;
  import ibus_pkg::*;

  logic [AW-1:0] CORE_A;
  logic [DW-1:0] CORE_DI;
  logic [1:0]    CORE_SZ;
  logic          CORE_WE;
  logic          CORE_REQ;
  logic [DW-1:0] CORE_DO;
  logic          CORE_ACK;
  logic          CORE_ADDR_ERR;
  logic [AW-1:0] IBUS_A;
  logic [DW-1:0] IBUS_DO;
  logic [DW-1:0] IBUS_DI;
  logic [BW-1:0] IBUS_BA;
  logic          IBUS_WE;
  logic          IBUS_REQ;
  logic          IBUS_BUSY;

  modport master (
    input  CORE_A, CORE_DI, CORE_SZ, CORE_WE, CORE_REQ, IBUS_DI, IBUS_BUSY,
    output CORE_DO, CORE_ACK, CORE_ADDR_ERR, IBUS_A, IBUS_DO, IBUS_BA, IBUS_WE, IBUS_REQ
  );

  modport slave (
    output CORE_A, CORE_DI, CORE_SZ, CORE_WE, CORE_REQ, IBUS_DI, IBUS_BUSY,
    input  CORE_DO, CORE_ACK, CORE_ADDR_ERR, IBUS_A, IBUS_DO, IBUS_BA, IBUS_WE, IBUS_REQ
  );
endinterface

// File: rtl/ibus_wbuf.sv
// One-entry posted-write buffer; a load in the same cycle as a drain wins.
module ibus_wbuf
  import ibus_pkg::*;
(
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          i_load,
  input  logic          i_drain,
  input  logic [AW-1:0] i_a,
  input  logic [DW-1:0] i_d,
  input  logic [BW-1:0] i_ba,
  output logic          o_valid,
  output logic [AW-1:0] o_a,
  output logic [DW-1:0] o_d,
  output logic [BW-1:0] o_ba
);

  logic          r_valid;
  logic [AW-1:0] r_a;
  logic [DW-1:0] r_d;
  logic [BW-1:0] r_ba;

  // Entry payload stays put after a drain so the bus lines do not toggle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_valid <= 1'b0;
      r_a     <= '0;
      r_d     <= '0;
      r_ba    <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_a     <= i_a;
      r_d     <= i_d;
      r_ba    <= i_ba;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_a     = r_a;
  assign o_d     = r_d;
  assign o_ba    = r_ba;

endmodule

// File: rtl/ibus_master.sv
// SH7034 IBUS initiator with a posted-write buffer.
// Define IBUS_MASTER_ADDR_ERR_EN to reject misaligned accesses instead of aligning them down.
module ibus_master
  import ibus_pkg::*;
(
  input logic           CLK,
  input logic           RST_N,
  input logic           CE_R,
  input logic           CE_F,
  ibus_master_if.master bus
);

  state_e        r_state;
  logic          r_ack;
  logic          r_req;
  logic          r_we;
  logic [DW-1:0] r_do;
  logic [AW-1:0] r_rd_a;
  logic [BW-1:0] r_rd_ba;

  logic          w_ce_f_unused;
  logic          w_mis;
  logic          w_take_st;
  logic          w_wb_load;
  logic          w_wb_drain;
  logic          w_wb_valid;
  logic [AW-1:0] w_req_a;
  logic [AW-1:0] w_wb_a;
  logic [BW-1:0] w_req_ba;
  logic [BW-1:0] w_wb_ba;
  logic [DW-1:0] w_req_d;
  logic [DW-1:0] w_wb_d;

  assign w_ce_f_unused = CE_F;

  assign w_req_a  = {bus.CORE_A[AW-1:2], 2'b00};
  assign w_req_ba = lane_en(bus.CORE_SZ, bus.CORE_A[1:0]);
  assign w_req_d  = wr_rep(bus.CORE_SZ, bus.CORE_DI);

`ifdef IBUS_MASTER_ADDR_ERR_EN
  logic r_err;
  assign w_mis = misaligned(bus.CORE_SZ, bus.CORE_A[1:0]);
  assign bus.CORE_ADDR_ERR = r_err;
`else
  assign w_mis = 1'b0;
  assign bus.CORE_ADDR_ERR = 1'b0;
`endif

  // A store may be taken from IDLE or on the drain edge of the current write.
  assign w_take_st  = bus.CORE_REQ & bus.CORE_WE & ~w_mis;
  assign w_wb_drain = CE_R & (r_state == WR) & ~bus.IBUS_BUSY;
  assign w_wb_load  = CE_R & w_take_st & (((r_state == IDLE) & ~w_wb_valid) | w_wb_drain);

  ibus_wbuf u_wbuf (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .i_load  (w_wb_load),
    .i_drain (w_wb_drain),
    .i_a     (w_req_a),
    .i_d     (w_req_d),
    .i_ba    (w_req_ba),
    .o_valid (w_wb_valid),
    .o_a     (w_wb_a),
    .o_d     (w_wb_d),
    .o_ba    (w_wb_ba)
  );

  // Request sequencing; every state change is qualified by CE_R.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
      r_ack   <= 1'b0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_do    <= '0;
      r_rd_a  <= '0;
      r_rd_ba <= '0;
`ifdef IBUS_MASTER_ADDR_ERR_EN
      r_err   <= 1'b0;
`endif
    end else if (CE_R) begin
      r_ack <= 1'b0;
`ifdef IBUS_MASTER_ADDR_ERR_EN
      r_err <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (bus.CORE_REQ && !w_wb_valid) begin
`ifdef IBUS_MASTER_ADDR_ERR_EN
            if (w_mis) begin
              r_ack <= 1'b1;
              r_err <= 1'b1;
            end else
`endif
            if (bus.CORE_WE) begin
              r_ack   <= 1'b1;
              r_req   <= 1'b1;
              r_we    <= 1'b1;
              r_state <= WR;
            end else begin
              r_rd_a  <= w_req_a;
              r_rd_ba <= w_req_ba;
              r_req   <= 1'b1;
              r_we    <= 1'b0;
              r_state <= RD;
            end
          end
        end
        WR: begin
          if (!bus.IBUS_BUSY) begin
            if (w_take_st) begin
              r_ack <= 1'b1;
            end else begin
              r_req   <= 1'b0;
              r_we    <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        RD: begin
          if (!bus.IBUS_BUSY) begin
            r_do    <= rd_ext(r_rd_ba, bus.IBUS_DI);
            r_ack   <= 1'b1;
            r_req   <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_we    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.CORE_DO  = r_do;
  assign bus.CORE_ACK = r_ack;
  assign bus.IBUS_REQ = r_req;
  assign bus.IBUS_WE  = r_we;
  assign bus.IBUS_A   = r_we ? w_wb_a  : r_rd_a;
  assign bus.IBUS_BA  = r_we ? w_wb_ba : r_rd_ba;
  assign bus.IBUS_DO  = w_wb_d;

endmodule

// File: tb/tb_ibus_master.sv
// Directed bench for ibus_master: stores, loads, BUSY stretches, CE_R gating and reset.
module tb_ibus_master;

  logic CLK;
  logic RST_N;
  logic CE_R;
  logic CE_F;
  int   n_chk;
  int   n_pass;
  int   n_fail;

  ibus_master_if bus ();

  ibus_master u_dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .CE_R  (CE_R),
    .CE_F  (CE_F),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] sz, input logic [27:0] a, input logic [31:0] d);
    bus.CORE_WE  = we;
    bus.CORE_SZ  = sz;
    bus.CORE_A   = a;
    bus.CORE_DI  = d;
    bus.CORE_REQ = 1'b1;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    n_fail = 0;
    RST_N = 1'b0;
    CE_R = 1'b1;
    CE_F = 1'b0;
    bus.CORE_A = 28'h0;
    bus.CORE_DI = 32'h0;
    bus.CORE_SZ = 2'd0;
    bus.CORE_WE = 1'b0;
    bus.CORE_REQ = 1'b0;
    bus.IBUS_DI = 32'h0;
    bus.IBUS_BUSY = 1'b0;

    // reset values
    tick();
    tick();
    chk("rst_req", bus.IBUS_REQ, 32'h0);
    chk("rst_we", bus.IBUS_WE, 32'h0);
    chk("rst_ack", bus.CORE_ACK, 32'h0);
    chk("rst_err", bus.CORE_ADDR_ERR, 32'h0);
    chk("rst_do", bus.CORE_DO, 32'h0);
    chk("rst_a", {4'h0, bus.IBUS_A}, 32'h0);
    chk("rst_ba", bus.IBUS_BA, 32'h0);
    chk("rst_ibus_do", bus.IBUS_DO, 32'h0);
    RST_N = 1'b1;
    tick();

    // byte store, zero-wait
    drive(1'b1, 2'd0, 28'hF000003, 32'h000000A5);
    tick();
    chk("bst_ack", bus.CORE_ACK, 32'h1);
    chk("bst_req", bus.IBUS_REQ, 32'h1);
    chk("bst_we", bus.IBUS_WE, 32'h1);
    chk("bst_a", {4'h0, bus.IBUS_A}, 32'h0F000000);
    chk("bst_ba", bus.IBUS_BA, 32'h1);
    chk("bst_do", bus.IBUS_DO, 32'hA5A5A5A5);
    bus.CORE_REQ = 1'b0;
    tick();
    chk("bst_ack_end", bus.CORE_ACK, 32'h0);
    chk("bst_req_end", bus.IBUS_REQ, 32'h0);
    chk("bst_we_end", bus.IBUS_WE, 32'h0);

    // word load, zero-wait
    drive(1'b0, 2'd1, 28'hF000002, 32'h0);
    bus.IBUS_DI = 32'h1234ABCD;
    tick();
    chk("wld_ack0", bus.CORE_ACK, 32'h0);
    chk("wld_req", bus.IBUS_REQ, 32'h1);
    chk("wld_we", bus.IBUS_WE, 32'h0);
    chk("wld_a", {4'h0, bus.IBUS_A}, 32'h0F000000);
    chk("wld_ba", bus.IBUS_BA, 32'h3);
    tick();
    chk("wld_ack", bus.CORE_ACK, 32'h1);
    chk("wld_do", bus.CORE_DO, 32'h0000ABCD);
    chk("wld_req_end", bus.IBUS_REQ, 32'h0);
    bus.CORE_REQ = 1'b0;
    tick();
    chk("wld_ack_pulse", bus.CORE_ACK, 32'h0);
    chk("wld_do_hold", bus.CORE_DO, 32'h0000ABCD);

    // long load with three BUSY cycles
    drive(1'b0, 2'd2, 28'hF000010, 32'h0);
    bus.IBUS_DI = 32'hCAFEF00D;
    bus.IBUS_BUSY = 1'b1;
    tick();
    chk("lld_req", bus.IBUS_REQ, 32'h1);
    chk("lld_a", {4'h0, bus.IBUS_A}, 32'h0F000010);
    chk("lld_ba", bus.IBUS_BA, 32'hF);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lld_busy_req", bus.IBUS_REQ, 32'h1);
      chk("lld_busy_a", {4'h0, bus.IBUS_A}, 32'h0F000010);
      chk("lld_busy_ba", bus.IBUS_BA, 32'hF);
      chk("lld_busy_ack", bus.CORE_ACK, 32'h0);
    end
    bus.IBUS_BUSY = 1'b0;
    tick();
    chk("lld_ack", bus.CORE_ACK, 32'h1);
    chk("lld_do", bus.CORE_DO, 32'hCAFEF00D);
    bus.CORE_REQ = 1'b0;
    tick();

    // store busy two cycles, load queued behind it
    drive(1'b1, 2'd2, 28'hF000020, 32'h11223344);
    bus.IBUS_BUSY = 1'b1;
    tick();
    chk("sl_st_ack", bus.CORE_ACK, 32'h1);
    chk("sl_st_we", bus.IBUS_WE, 32'h1);
    chk("sl_st_do", bus.IBUS_DO, 32'h11223344);
    drive(1'b0, 2'd2, 28'hF000024, 32'h0);
    bus.IBUS_DI = 32'h55667788;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("sl_stall_ack", bus.CORE_ACK, 32'h0);
      chk("sl_stall_we", bus.IBUS_WE, 32'h1);
      chk("sl_stall_a", {4'h0, bus.IBUS_A}, 32'h0F000020);
    end
    bus.IBUS_BUSY = 1'b0;
    tick();
    chk("sl_drain_req", bus.IBUS_REQ, 32'h0);
    chk("sl_drain_ack", bus.CORE_ACK, 32'h0);
    tick();
    chk("sl_rd_req", bus.IBUS_REQ, 32'h1);
    chk("sl_rd_we", bus.IBUS_WE, 32'h0);
    chk("sl_rd_a", {4'h0, bus.IBUS_A}, 32'h0F000024);
    tick();
    chk("sl_rd_ack", bus.CORE_ACK, 32'h1);
    chk("sl_rd_do", bus.CORE_DO, 32'h55667788);
    bus.CORE_REQ = 1'b0;
    tick();

    // misaligned long load
    drive(1'b0, 2'd2, 28'hF000001, 32'h0);
    bus.IBUS_DI = 32'h0BADBEEF;
    tick();
`ifdef IBUS_MASTER_ADDR_ERR_EN
    chk("mis_req", bus.IBUS_REQ, 32'h0);
    chk("mis_ack", bus.CORE_ACK, 32'h1);
    chk("mis_err", bus.CORE_ADDR_ERR, 32'h1);
    chk("mis_do", bus.CORE_DO, 32'h55667788);
    bus.CORE_REQ = 1'b0;
    tick();
    chk("mis_err_pulse", bus.CORE_ADDR_ERR, 32'h0);
`else
    chk("mis_req", bus.IBUS_REQ, 32'h1);
    chk("mis_a", {4'h0, bus.IBUS_A}, 32'h0F000000);
    chk("mis_ba", bus.IBUS_BA, 32'hF);
    chk("mis_err", bus.CORE_ADDR_ERR, 32'h0);
    tick();
    chk("mis_ack", bus.CORE_ACK, 32'h1);
    chk("mis_do", bus.CORE_DO, 32'h0BADBEEF);
    bus.CORE_REQ = 1'b0;
    tick();
`endif

    // back-to-back stores taken on the drain edge
    drive(1'b1, 2'd0, 28'hF000040, 32'h0000005A);
    tick();
    chk("bb1_ba", bus.IBUS_BA, 32'h8);
    chk("bb1_do", bus.IBUS_DO, 32'h5A5A5A5A);
    drive(1'b1, 2'd1, 28'hF000046, 32'h0000BEEF);
    tick();
    chk("bb2_ack", bus.CORE_ACK, 32'h1);
    chk("bb2_we", bus.IBUS_WE, 32'h1);
    chk("bb2_a", {4'h0, bus.IBUS_A}, 32'h0F000044);
    chk("bb2_ba", bus.IBUS_BA, 32'h3);
    chk("bb2_do", bus.IBUS_DO, 32'hBEEFBEEF);
    bus.CORE_REQ = 1'b0;
    tick();
    chk("bb_end_req", bus.IBUS_REQ, 32'h0);

    // CE_R gating on a byte load
    drive(1'b0, 2'd0, 28'hF000051, 32'h0);
    bus.IBUS_DI = 32'h11AB2233;
    CE_R = 1'b0;
    tick();
    chk("ce_hold_req", bus.IBUS_REQ, 32'h0);
    CE_R = 1'b1;
    tick();
    chk("ce_req", bus.IBUS_REQ, 32'h1);
    chk("ce_ba", bus.IBUS_BA, 32'h4);
    CE_R = 1'b0;
    tick();
    chk("ce_hold_ack", bus.CORE_ACK, 32'h0);
    CE_R = 1'b1;
    tick();
    chk("ce_ack", bus.CORE_ACK, 32'h1);
    chk("ce_do", bus.CORE_DO, 32'h000000AB);
    bus.CORE_REQ = 1'b0;
    tick();

    // reset during a busy read
    drive(1'b0, 2'd2, 28'hF000060, 32'h0);
    bus.IBUS_BUSY = 1'b1;
    tick();
    chk("rrd_req", bus.IBUS_REQ, 32'h1);
    tick();
    RST_N = 1'b0;
    #1;
    chk("rrd_async_req", bus.IBUS_REQ, 32'h0);
    chk("rrd_async_ack", bus.CORE_ACK, 32'h0);
    tick();
    RST_N = 1'b1;
    bus.CORE_REQ = 1'b0;
    bus.IBUS_BUSY = 1'b0;
    tick();
    chk("rrd_post_req", bus.IBUS_REQ, 32'h0);
    chk("rrd_post_ack", bus.CORE_ACK, 32'h0);
    chk("rrd_post_do", bus.CORE_DO, 32'h0);
    drive(1'b0, 2'd1, 28'hF000070, 32'h0);
    bus.IBUS_DI = 32'h43210000;
    tick();
    chk("rrd_new_req", bus.IBUS_REQ, 32'h1);
    chk("rrd_new_we", bus.IBUS_WE, 32'h0);
    chk("rrd_new_ba", bus.IBUS_BA, 32'hC);
    tick();
    chk("rrd_new_ack", bus.CORE_ACK, 32'h1);
    chk("rrd_new_do", bus.CORE_DO, 32'h00004321);
    bus.CORE_REQ = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
